// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ADJ   = 2'd2
   } state_t;

   localparam int DEF_NDIG = 32'sd3;
   localparam int DEF_BW   = 32'sd10;

   // Smallest binary width whose range covers every NDIG-digit decimal value.
   function automatic int bcd_bin_width(input int ndig);
      longint p10;
      longint p2;
      int     bw;
      p10 = 64'sd1;
      p2  = 64'sd1;
      bw  = 32'sd0;
      for (int i = 0; i < ndig; i++) begin
         p10 = p10 * 64'sd10;
      end
      while (p2 < p10) begin
         p2 = p2 * 64'sd2;
         bw = bw + 32'sd1;
      end
      return bw;
   endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Start/done handshake bundle between a requester and the BCD-to-binary converter.
interface bcd_to_bin_if
   import bcd_pkg::*;
#(
   parameter int NDIG = DEF_NDIG,
   parameter int BW   = DEF_BW
);
   logic                st;
   logic [4*NDIG-1:0]   bcd;
   logic [BW-1:0]       bin;
   logic                busy;
   logic                done;
   logic                err;

   modport master (output st, bcd, input bin, busy, done, err);
   modport slave  (input st, bcd, output bin, busy, done, err);
endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of the reverse double-dabble: digits of 8 or more lose 3.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= 4'd8) ? (d - 4'd3) : d;
endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, shift-right / subtract-3).
// Optional input digit validation is enabled by defining BCD_TO_BIN_CHECK_EN.
module bcd_to_bin
   import bcd_pkg::*;
#(
   parameter int NDIG = DEF_NDIG,
   parameter int BW   = DEF_BW
)(
   input  logic         clk,
   input  logic         rst_n,
   bcd_to_bin_if.slave  bus
);
   localparam int DW = 4 * NDIG;
   localparam int CW = $clog2(BW + 1);
   localparam logic [CW-1:0] BW_C = CW'(BW);

   state_t          state_r, state_s;
   logic [DW-1:0]   acc_bcd_r, acc_bcd_s;
   logic [BW-1:0]   acc_bin_r, acc_bin_s;
   logic [CW-1:0]   count_r, count_s;
   logic [BW-1:0]   bin_r, bin_s;
   logic            busy_r, busy_s;
   logic            done_r, done_s;
   logic            err_r, err_s;
   logic [DW-1:0]   adj_s;

   for (genvar g = 0; g < NDIG; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d (acc_bcd_r[4*g +: 4]),
         .q (adj_s[4*g +: 4])
      );
   end

`ifdef BCD_TO_BIN_CHECK_EN
   logic pend_r, pend_s;

   function automatic logic has_bad_digit(input logic [DW-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end else begin
            bad = bad;
         end
      end
      return bad;
   endfunction
`endif

   // Next-state and datapath decode for the IDLE / SHIFT / ADJ sequence.
   always_comb begin
      state_s   = state_r;
      acc_bcd_s = acc_bcd_r;
      acc_bin_s = acc_bin_r;
      count_s   = count_r;
      bin_s     = bin_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      err_s     = 1'b0;
`ifdef BCD_TO_BIN_CHECK_EN
      pend_s    = pend_r;
`endif
      case (state_r)
         IDLE: begin
            if (bus.st) begin
               acc_bin_s = '0;
               busy_s    = 1'b1;
`ifdef BCD_TO_BIN_CHECK_EN
               // A bad word jumps straight to the final ADJ so it completes one edge later.
               if (has_bad_digit(bus.bcd)) begin
                  acc_bcd_s = '0;
                  count_s   = BW_C;
                  pend_s    = 1'b1;
                  state_s   = ADJ;
               end else begin
                  acc_bcd_s = bus.bcd;
                  count_s   = '0;
                  pend_s    = 1'b0;
                  state_s   = SHIFT;
               end
`else
               acc_bcd_s = bus.bcd;
               count_s   = '0;
               state_s   = SHIFT;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            acc_bcd_s = {1'b0, acc_bcd_r[DW-1:1]};
            acc_bin_s = {acc_bcd_r[0], acc_bin_r[BW-1:1]};
            count_s   = count_r + CW'(1'b1);
            state_s   = ADJ;
         end
         ADJ: begin
            acc_bcd_s = adj_s;
            if (count_r == BW_C) begin
               bin_s   = acc_bin_r;
               done_s  = 1'b1;
               busy_s  = 1'b0;
`ifdef BCD_TO_BIN_CHECK_EN
               err_s   = pend_r;
               pend_s  = 1'b0;
`else
               err_s   = 1'b0;
`endif
               state_s = IDLE;
            end else begin
               state_s = SHIFT;
            end
         end
         default: begin
            busy_s  = 1'b0;
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         acc_bcd_r <= '0;
         acc_bin_r <= '0;
         count_r   <= '0;
         bin_r     <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
`ifdef BCD_TO_BIN_CHECK_EN
         pend_r    <= 1'b0;
`endif
      end else begin
         state_r   <= state_s;
         acc_bcd_r <= acc_bcd_s;
         acc_bin_r <= acc_bin_s;
         count_r   <= count_s;
         bin_r     <= bin_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         err_r     <= err_s;
`ifdef BCD_TO_BIN_CHECK_EN
         pend_r    <= pend_s;
`endif
      end
   end

   assign bus.bin  = bin_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.err  = err_r;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed table, hand sequences, random and exhaustive sweeps.
module tb_bcd_to_bin;
   import bcd_pkg::*;

   localparam int NDIG = 3;
   localparam int BW   = 10;
   localparam int LAT  = 2 * BW;

   typedef struct {
      logic [4*NDIG-1:0] bcd;
      int                bin;
      bit                err;
      int                lat;
      bit                chk;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt = 0;

   always #5 clk = ~clk;

   bcd_to_bin_if #(.NDIG(NDIG), .BW(BW)) bus ();

   bcd_to_bin #(.NDIG(NDIG), .BW(BW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always @(posedge clk) begin
      if (bus.done === 1'b1) done_cnt++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   // Decimal value of a packed BCD word, plain positional arithmetic.
   function automatic int ref_bin(input logic [4*NDIG-1:0] b);
      int v = 0;
      for (int i = NDIG - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
      return v;
   endfunction

   function automatic logic [4*NDIG-1:0] to_bcd(input int v);
      logic [4*NDIG-1:0] b;
      int t = v;
      for (int i = 0; i < NDIG; i++) begin
         b[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return b;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Issue one start (caller is just after an edge) and wait for done.
   task automatic convert(input logic [4*NDIG-1:0] b, input bit hold,
                          output int got_bin, output bit got_err,
                          output int lat, output bit acc_zero);
      bit busy_ok = 1'b1;
      bus.bcd = b;
      bus.st  = 1'b1;
      @(posedge clk); #1;
      check("start_no_done", bus.done, 0);
      if (hold) begin
         bus.bcd = {NDIG{4'h9}};
      end else begin
         bus.st  = 1'b0;
         bus.bcd = (4*NDIG)'($urandom);
      end
      lat = 0;
      while (bus.done !== 1'b1 && lat < 4 * LAT) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check("busy_span", busy_ok, 1);
      check("busy_clr", bus.busy, 0);
      got_bin  = int'(bus.bin);
      got_err  = bus.err;
      acc_zero = (dut.acc_bcd_r == '0);
      bus.st   = 1'b0;
   endtask

   initial begin
      vec_t tbl[10];
      int   gb, lat, base;
      bit   ge, az;
      logic [4*NDIG-1:0] b;

      tbl[0] = '{12'h999, 999, 1'b0, LAT, 1'b1};
      tbl[1] = '{12'h000, 0,   1'b0, LAT, 1'b1};
      tbl[2] = '{12'h128, 128, 1'b0, LAT, 1'b1};
      tbl[3] = '{12'h255, 255, 1'b0, LAT, 1'b1};
      tbl[4] = '{12'h001, 1,   1'b0, LAT, 1'b1};
      tbl[5] = '{12'h900, 900, 1'b0, LAT, 1'b1};
      tbl[6] = '{12'h090, 90,  1'b0, LAT, 1'b1};
      tbl[7] = '{12'h512, 512, 1'b0, LAT, 1'b1};
`ifdef BCD_TO_BIN_CHECK_EN
      tbl[8] = '{12'hA05, 0,   1'b1, 1,   1'b1};
`else
      tbl[8] = '{12'hA05, 0,   1'b0, LAT, 1'b0};
`endif
      tbl[9] = '{12'h707, 707, 1'b0, LAT, 1'b1};

      rst_n   = 1'b0;
      bus.st  = 1'b0;
      bus.bcd = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bin", bus.bin, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_count", dut.count_r, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table, issued back-to-back.
      for (int i = 0; i < 10; i++) begin
         convert(tbl[i].bcd, 1'b0, gb, ge, lat, az);
         check("tbl_lat", lat, tbl[i].lat);
         check("tbl_err", ge, tbl[i].err);
         if (tbl[i].chk) begin
            check("tbl_bin", gb, tbl[i].bin);
            check("tbl_acc_zero", az, 1);
         end
      end

      // st held high with bcd changing: one conversion only.
      @(posedge clk); #1;
      base = done_cnt;
      convert(12'h407, 1'b1, gb, ge, lat, az);
      check("hold_bin", gb, 407);
      check("hold_lat", lat, LAT);
      @(posedge clk); #1;
      check("hold_done_1cyc", bus.done, 0);
      check("hold_idle", bus.busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_single_done", done_cnt - base, 1);

      // Reset in the middle of a conversion.
      bus.bcd = 12'h999;
      bus.st  = 1'b1;
      @(posedge clk); #1;
      bus.st = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_bin", bus.bin, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_done", bus.done, 0);
      check("mid_rst_err", bus.err, 0);
      base = done_cnt;
      repeat (25) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      check("mid_rst_no_done", done_cnt - base, 0);
      check("mid_rst_no_resume", bus.busy, 0);
      convert(12'h050, 1'b0, gb, ge, lat, az);
      check("post_rst_bin", gb, 50);
      check("post_rst_lat", lat, LAT);

      // Random valid words with random idle gaps.
      for (int n = 0; n < 300; n++) begin
         for (int d = 0; d < NDIG; d++) b[4*d +: 4] = 4'($urandom_range(0, 9));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         convert(b, 1'b0, gb, ge, lat, az);
         check("rnd_bin", gb, ref_bin(b));
         check("rnd_err", ge, 0);
         check("rnd_lat", lat, LAT);
      end

      // Exhaustive sweep of every valid word.
      for (int v = 0; v < 1000; v++) begin
         convert(to_bcd(v), 1'b0, gb, ge, lat, az);
         check("sweep_bin", gb, v);
         check("sweep_acc_zero", az, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
